store_merge: RTL and testbench
==============================

STORE_MERGE -- requirements
Module: store_merge

Interface
REQ-001 SHALL provide port clk, input, 1: single clock; all state updates on its rising edge.
REQ-002 SHALL provide port reset, input, 1: asynchronous, active-low reset.
REQ-003 SHALL provide port req_valid, input, 1: store request present.
REQ-004 SHALL provide port req_ready, output, 1: block accepts a request this cycle.
REQ-005 SHALL provide port req_type, input, 2: 00=SW, 01=SH, 10=SB, 11=reserved.
REQ-006 SHALL provide port req_addr, input, 32: byte address.
REQ-007 SHALL provide port req_data, input, 32: register data; the narrow value sits in the low bits.
REQ-008 SHALL provide port mem_addr, output, 32: word address; bits [1:0] are always 00.
REQ-009 SHALL provide port mem_rd, output, 1: one-cycle read strobe to word-wide memory.
REQ-010 SHALL provide port mem_rdata, input, 32: read data, valid exactly one cycle after mem_rd.
REQ-011 SHALL provide port mem_we, output, 1: one-cycle full-word write strobe.
REQ-012 SHALL provide port mem_wdata, output, 32: merged write word.
REQ-013 SHALL provide port mem_be, output, 4: byte lanes modified, for trace/debug; lane k = bits [8k+7:8k].
REQ-014 SHALL provide port done, output, 1: one-cycle pulse on store completion.
REQ-015 SHALL provide port err, output, 1: one-cycle pulse on rejected request.

Function
REQ-016 SHALL implement FSM states IDLE, READ, WAIT, WRITE, DONE, ERR.
REQ-017 SHALL assert req_ready only in IDLE; a request is accepted on a clock edge with req_valid=1 in IDLE.
REQ-018 SHALL latch req_type, req_addr, and req_data at acceptance; later changes to the inputs have no effect.
REQ-019 SHALL take IDLE->ERR on a reserved type, on SH with addr[0]=1, or on SW with addr[1:0]!=00; ERR asserts err for one cycle, then returns to IDLE with no memory access.
REQ-020 SHALL take IDLE->WRITE for a valid SW: mem_wdata=req_data, mem_be=1111, no read.
REQ-021 SHALL take IDLE->READ for a valid SH or SB: mem_rd=1 and mem_addr={addr[31:2],2'b00} for one cycle, then go to WAIT.
REQ-022 SHALL, in WAIT, capture mem_rdata into the merge register, then go to WRITE.
REQ-023 SHALL, for SB, replace lane addr[1:0] with req_data[7:0] and keep the other lanes from mem_rdata.
REQ-024 SHALL, for SH, replace lanes {2h+1,2h} (h=addr[1]) with req_data[15:0] and keep the other lanes.
REQ-025 SHALL, in WRITE, assert mem_we with mem_addr and the merged mem_wdata for one cycle, then go to DONE.
REQ-026 SHALL, in DONE, pulse done for one cycle, then go to IDLE; req_ready returns in the cycle after DONE.
REQ-027 SHALL meet these latencies from the acceptance edge: SW has mem_we in cycle 1 and done in cycle 2; SH/SB have mem_rd in cycle 1, mem_we in cycle 3, and done in cycle 4; error has err in cycle 1.
REQ-028 SHALL never assert mem_rd and mem_we in the same cycle, and at most one of done/err per request.
REQ-029 SHALL drive mem_be=0000 outside WRITE, and mem_wdata=0 outside WRITE.

Reset
REQ-030 SHALL, on reset=0, immediately force IDLE and drive req_ready=1 (once reset=1), mem_rd=0, mem_we=0, done=0, err=0, mem_addr=0, mem_wdata=0, mem_be=0000.
REQ-031 SHALL abandon any in-flight store on reset assertion mid-operation, with no write issued afterwards.
REQ-032 SHALL accept a request on the first rising edge after reset deasserts.

Verification
REQ-033 SHALL cover: SW addr=0x100, data=0xDEADBEEF -> cycle 1 mem_we=1, mem_addr=0x100, mem_wdata=0xDEADBEEF, mem_be=1111; cycle 2 done=1.
REQ-034 SHALL cover: SB addr=0x203, data=0x000000AB, mem_rdata=0x11223344 -> mem_rd at cycle 1 with mem_addr=0x200; mem_wdata=0xAB223344, mem_be=1000 at cycle 3.
REQ-035 SHALL cover: SH addr=0x302, data=0x0000CAFE, mem_rdata=0x11223344 -> mem_wdata=0xCAFE3344, mem_be=1100.
REQ-036 SHALL cover: SH addr=0x301, then SW addr=0x102, then type=11 -> err=1 at cycle 1 for each, with no mem_rd or mem_we.
REQ-037 SHALL cover: reset=0 in WAIT of an SB -> outputs zeroed asynchronously, no mem_we ever follows, and a new SW is accepted after release.
REQ-038 SHALL cover: req_valid held high back-to-back with two SB requests -> the second is accepted only after DONE, and req_ready=0 throughout.

Source files
------------

// File: rtl/store_merge.sv
// store_merge: turns byte/half/word store requests into full-word memory
// accesses. Word stores are written directly. Byte and halfword stores do a
// read-modify-write: read the containing word, splice the new lanes in, then
// write the whole word back.
//
// State table
//   state | meaning
//   IDLE  | ready for a request (req_ready=1)
//   READ  | mem_rd strobe for the containing word
//   WAIT  | mem_rdata valid; merge the new lanes into it
//   WRITE | mem_we strobe with the merged word
//   DONE  | done pulse
//   ERR   | err pulse for a rejected request, no memory access
//
// Ports
//   clk        : clock, rising edge
//   reset      : asynchronous active-low reset
//   req_valid  : store request present
//   req_ready  : request accepted on this cycle's edge when valid
//   req_type   : 00=SW, 01=SH, 10=SB, 11=reserved
//   req_addr   : byte address
//   req_data   : store data, narrow values in the low bits
//   mem_addr   : word address (bits [1:0] always 0) during READ/WRITE
//   mem_rd     : one-cycle read strobe
//   mem_rdata  : read data, valid the cycle after mem_rd
//   mem_we     : one-cycle full-word write strobe
//   mem_wdata  : merged write word (0 outside WRITE)
//   mem_be     : modified byte lanes (0 outside WRITE)
//   done       : one-cycle completion pulse
//   err        : one-cycle rejection pulse
module store_merge (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_type,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  output logic [31:0] mem_addr,
  output logic        mem_rd,
  input  logic [31:0] mem_rdata,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WAIT  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4,
    ERR   = 3'd5
  } state_t;

  localparam logic [1:0] TYPE_SW = 2'b00;
  localparam logic [1:0] TYPE_SH = 2'b01;
  localparam logic [1:0] TYPE_SB = 2'b10;

  state_t      state_q, state_d;
  logic [1:0]  type_q, type_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [31:0] merge_q, merge_d;

  logic        req_ready_q, req_ready_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic        mem_rd_q, mem_rd_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  function automatic logic is_bad(input logic [1:0] t, input logic [1:0] a);
    return (t == 2'b11) ||
           ((t == TYPE_SH) && a[0]) ||
           ((t == TYPE_SW) && (a != 2'b00));
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] t, input logic [1:0] a);
    case (t)
      TYPE_SW: return 4'b1111;
      TYPE_SH: return a[1] ? 4'b1100 : 4'b0011;
      TYPE_SB: return 4'b0001 << a;
      default: return 4'b0000;
    endcase
  endfunction

  // Replicating the narrow value across the word puts it in every lane, so the
  // lane mask alone decides which copy lands in memory.
  function automatic logic [31:0] spread(input logic [1:0] t, input logic [31:0] d);
    case (t)
      TYPE_SH: return {2{d[15:0]}};
      TYPE_SB: return {4{d[7:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] merge_word(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  be);
    logic [31:0] w;
    for (int k = 0; k < 4; k++) begin
      w[8*k +: 8] = be[k] ? new_w[8*k +: 8] : old_w[8*k +: 8];
    end
    return w;
  endfunction

  always_comb begin
    state_d = state_q;
    type_d  = type_q;
    addr_d  = addr_q;
    data_d  = data_q;
    merge_d = merge_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          type_d = req_type;
          addr_d = req_addr;
          data_d = req_data;
          if (is_bad(req_type, req_addr[1:0])) begin
            state_d = ERR;
          end else if (req_type == TYPE_SW) begin
            merge_d = req_data;
            state_d = WRITE;
          end else begin
            state_d = READ;
          end
        end
      end
      READ:  state_d = WAIT;
      WAIT: begin
        merge_d = merge_word(mem_rdata, spread(type_q, data_q),
                             lane_mask(type_q, addr_q[1:0]));
        state_d = WRITE;
      end
      WRITE: state_d = DONE;
      DONE:  state_d = IDLE;
      ERR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so each strobe lines up with
    // the cycle its state occupies.
    req_ready_d = (state_d == IDLE);
    mem_rd_d    = (state_d == READ);
    mem_we_d    = (state_d == WRITE);
    done_d      = (state_d == DONE);
    err_d       = (state_d == ERR);
    mem_addr_d  = ((state_d == READ) || (state_d == WRITE)) ? {addr_d[31:2], 2'b00} : 32'd0;
    mem_wdata_d = (state_d == WRITE) ? merge_d : 32'd0;
    mem_be_d    = (state_d == WRITE) ? lane_mask(type_d, addr_d[1:0]) : 4'b0000;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      type_q      <= 2'b00;
      addr_q      <= 32'd0;
      data_q      <= 32'd0;
      merge_q     <= 32'd0;
      req_ready_q <= 1'b1;
      mem_addr_q  <= 32'd0;
      mem_rd_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= 32'd0;
      mem_be_q    <= 4'b0000;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      type_q      <= type_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      merge_q     <= merge_d;
      req_ready_q <= req_ready_d;
      mem_addr_q  <= mem_addr_d;
      mem_rd_q    <= mem_rd_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign req_ready = req_ready_q;
  assign mem_addr  = mem_addr_q;
  assign mem_rd    = mem_rd_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_store_merge.sv
module tb_store_merge;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_type;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [31:0] mem_addr;
  logic        mem_rd;
  logic [31:0] mem_rdata;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        done;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [31:0] JUNK = 32'h5A5A_5A5A;

  store_merge dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_type  (req_type),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_rdata (mem_rdata),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents a request, lets one edge accept it, then scrambles the inputs so
  // anything not latched at acceptance shows up as wrong data.
  task automatic issue(input logic [1:0] t, input logic [31:0] a, input logic [31:0] d);
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL issue_ready: req_ready=%b required 1", req_ready);
    end
    req_valid = 1'b1;
    req_type  = t;
    req_addr  = a;
    req_data  = d;
    step();
    req_valid = 1'b0;
    req_type  = 2'b11;
    req_addr  = 32'hFFFF_FFFF;
    req_data  = 32'hFFFF_FFFF;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #2;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({mem_rd, mem_we, done, err} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_strobes: rd/we/done/err=%b required 0000", {mem_rd, mem_we, done, err});
    end
    n_checks++;
    if (mem_addr !== 32'd0 || mem_wdata !== 32'd0 || mem_be !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_buses: addr=%h wdata=%h be=%b required 0/0/0000", mem_addr, mem_wdata, mem_be);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: req_ready=%b required 1", req_ready);
    end
  endtask

  task automatic test_sw();
    issue(2'b00, 32'h0000_0100, 32'hDEAD_BEEF);
    n_checks++;
    if (mem_we !== 1'b1 || mem_rd !== 1'b0 || req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL sw_c1_strobes: we=%b rd=%b ready=%b required 1/0/0", mem_we, mem_rd, req_ready);
    end
    n_checks++;
    if (mem_addr !== 32'h0000_0100 || mem_wdata !== 32'hDEAD_BEEF || mem_be !== 4'b1111) begin
      n_fail++;
      $display("FAIL sw_c1_data: addr=%h wdata=%h be=%b required 00000100/deadbeef/1111", mem_addr, mem_wdata, mem_be);
    end
    step();
    n_checks++;
    if (done !== 1'b1 || mem_we !== 1'b0 || mem_be !== 4'b0000 || mem_wdata !== 32'd0) begin
      n_fail++;
      $display("FAIL sw_c2_done: done=%b we=%b be=%b wdata=%h required 1/0/0000/0", done, mem_we, mem_be, mem_wdata);
    end
    step();
    n_checks++;
    if (req_ready !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL sw_c3_idle: ready=%b done=%b required 1/0", req_ready, done);
    end
  endtask

  task automatic test_merge(input logic [1:0] t, input logic [31:0] a, input logic [31:0] d,
                            input logic [31:0] rdata, input logic [31:0] exp_addr,
                            input logic [31:0] exp_wdata, input logic [3:0] exp_be);
    mem_rdata = JUNK;
    issue(t, a, d);
    n_checks++;
    if (mem_rd !== 1'b1 || mem_we !== 1'b0 || mem_addr !== exp_addr || mem_be !== 4'b0000) begin
      n_fail++;
      $display("FAIL merge_c1_read a=%h: rd=%b we=%b addr=%h be=%b required 1/0/%h/0000", a, mem_rd, mem_we, mem_addr, mem_be, exp_addr);
    end
    step();
    mem_rdata = rdata;
    n_checks++;
    if (mem_rd !== 1'b0 || mem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL merge_c2_wait a=%h: rd=%b we=%b required 0/0", a, mem_rd, mem_we);
    end
    step();
    mem_rdata = JUNK;
    n_checks++;
    if (mem_we !== 1'b1 || mem_addr !== exp_addr || mem_wdata !== exp_wdata || mem_be !== exp_be) begin
      n_fail++;
      $display("FAIL merge_c3_write a=%h: we=%b addr=%h wdata=%h be=%b required 1/%h/%h/%b", a, mem_we, mem_addr, mem_wdata, mem_be, exp_addr, exp_wdata, exp_be);
    end
    step();
    n_checks++;
    if (done !== 1'b1 || mem_we !== 1'b0 || req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL merge_c4_done a=%h: done=%b we=%b ready=%b required 1/0/0", a, done, mem_we, req_ready);
    end
    step();
  endtask

  task automatic test_err(input logic [1:0] t, input logic [31:0] a);
    issue(t, a, 32'h1234_5678);
    n_checks++;
    if (err !== 1'b1 || mem_rd !== 1'b0 || mem_we !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL err_c1 t=%b a=%h: err=%b rd=%b we=%b done=%b required 1/0/0/0", t, a, err, mem_rd, mem_we, done);
    end
    step();
    n_checks++;
    if (err !== 1'b0 || req_ready !== 1'b1 || mem_rd !== 1'b0 || mem_we !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL err_c2 t=%b a=%h: err=%b ready=%b rd=%b we=%b done=%b required 0/1/0/0/0", t, a, err, req_ready, mem_rd, mem_we, done);
    end
  endtask

  task automatic test_reset_mid();
    int we_seen;
    we_seen = 0;
    mem_rdata = JUNK;
    issue(2'b10, 32'h0000_0203, 32'h0000_00AB);
    step();
    mem_rdata = 32'h1122_3344;
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if (req_ready !== 1'b1 || {mem_rd, mem_we, done, err} !== 4'b0000 ||
        mem_addr !== 32'd0 || mem_wdata !== 32'd0 || mem_be !== 4'b0000) begin
      n_fail++;
      $display("FAIL rstmid_async: ready=%b rd/we/done/err=%b addr=%h wdata=%h be=%b required 1/0000/0/0/0000", req_ready, {mem_rd, mem_we, done, err}, mem_addr, mem_wdata, mem_be);
    end
    mem_rdata = JUNK;
    repeat (2) begin
      step();
      if (mem_we !== 1'b0) we_seen++;
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (4) begin
      step();
      if (mem_we !== 1'b0 || done !== 1'b0) we_seen++;
    end
    n_checks++;
    if (we_seen !== 0) begin
      n_fail++;
      $display("FAIL rstmid_no_write: stray we/done cycles=%0d required 0", we_seen);
    end
    issue(2'b00, 32'h0000_0040, 32'h0BAD_F00D);
    n_checks++;
    if (mem_we !== 1'b1 || mem_addr !== 32'h0000_0040 || mem_wdata !== 32'h0BAD_F00D) begin
      n_fail++;
      $display("FAIL rstmid_new_sw: we=%b addr=%h wdata=%h required 1/00000040/0badf00d", mem_we, mem_addr, mem_wdata);
    end
    step();
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_new_done: done=%b required 1", done);
    end
    step();
  endtask

  task automatic test_back_to_back();
    int early;
    early = 0;
    mem_rdata = JUNK;
    req_valid = 1'b1;
    req_type  = 2'b10;
    req_addr  = 32'h0000_0401;
    req_data  = 32'h0000_00CD;
    step();
    // Second request sits on the inputs, valid held high, during the first.
    req_addr  = 32'h0000_0402;
    req_data  = 32'h1234_5677;
    n_checks++;
    if (mem_rd !== 1'b1 || mem_addr !== 32'h0000_0400 || req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_c1: rd=%b addr=%h ready=%b required 1/00000400/0", mem_rd, mem_addr, req_ready);
    end
    step();
    mem_rdata = 32'hAABB_CCDD;
    if (req_ready !== 1'b0 || mem_rd !== 1'b0) early++;
    step();
    mem_rdata = JUNK;
    if (req_ready !== 1'b0 || mem_rd !== 1'b0) early++;
    n_checks++;
    if (mem_we !== 1'b1 || mem_wdata !== 32'hAABB_CDDD || mem_be !== 4'b0010) begin
      n_fail++;
      $display("FAIL b2b_first_write: we=%b wdata=%h be=%b required 1/aabbcddd/0010", mem_we, mem_wdata, mem_be);
    end
    step();
    if (req_ready !== 1'b0 || mem_rd !== 1'b0 || done !== 1'b1) early++;
    n_checks++;
    if (early !== 0) begin
      n_fail++;
      $display("FAIL b2b_busy: cycles with ready/rd/done wrong=%0d required 0", early);
    end
    step();
    n_checks++;
    if (req_ready !== 1'b1 || mem_rd !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_idle_gap: ready=%b rd=%b done=%b required 1/0/0", req_ready, mem_rd, done);
    end
    step();
    req_valid = 1'b0;
    req_addr  = 32'hFFFF_FFFF;
    req_data  = 32'hFFFF_FFFF;
    n_checks++;
    if (mem_rd !== 1'b1 || mem_addr !== 32'h0000_0400 || req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_second_read: rd=%b addr=%h ready=%b required 1/00000400/0", mem_rd, mem_addr, req_ready);
    end
    step();
    mem_rdata = 32'h0102_0304;
    step();
    mem_rdata = JUNK;
    n_checks++;
    if (mem_we !== 1'b1 || mem_wdata !== 32'h0177_0304 || mem_be !== 4'b0100) begin
      n_fail++;
      $display("FAIL b2b_second_write: we=%b wdata=%h be=%b required 1/01770304/0100", mem_we, mem_wdata, mem_be);
    end
    step();
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_second_done: done=%b required 1", done);
    end
    step();
  endtask

  initial begin
    req_valid = 1'b0;
    req_type  = 2'b00;
    req_addr  = 32'd0;
    req_data  = 32'd0;
    mem_rdata = JUNK;
    test_reset();
    test_sw();
    test_merge(2'b10, 32'h0000_0203, 32'h0000_00AB, 32'h1122_3344, 32'h0000_0200, 32'hAB22_3344, 4'b1000);
    test_merge(2'b01, 32'h0000_0302, 32'h0000_CAFE, 32'h1122_3344, 32'h0000_0300, 32'hCAFE_3344, 4'b1100);
    test_merge(2'b01, 32'h0000_0300, 32'hFFFF_1234, 32'h1122_3344, 32'h0000_0300, 32'h1122_1234, 4'b0011);
    test_merge(2'b10, 32'h0000_0200, 32'hFFFF_FFAB, 32'h1122_3344, 32'h0000_0200, 32'h1122_33AB, 4'b0001);
    test_err(2'b01, 32'h0000_0301);
    test_err(2'b00, 32'h0000_0102);
    test_err(2'b11, 32'h0000_0100);
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
